// File: rtl/hms_pkg.sv
// hms_pkg: shared constants and helpers for the hour/minute/second
// time-set controller.
//   - Mode encodings: CLOCK -> SET_SEC -> SET_MIN -> SET_HOUR -> CLOCK.
//   - Field limits for seconds and minutes.
//   - Digit index constants for the six-digit display (bit0 = sec ones ..
//     bit5 = hour tens). The same order is used by the blank and dp masks.
package hms_pkg;

    localparam logic [1:0] MODE_CLOCK    = 2'd0;
    localparam logic [1:0] MODE_SET_SEC  = 2'd1;
    localparam logic [1:0] MODE_SET_MIN  = 2'd2;
    localparam logic [1:0] MODE_SET_HOUR = 2'd3;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;

    localparam int DIG_SEC1   = 0;
    localparam int DIG_SEC10  = 1;
    localparam int DIG_MIN1   = 2;
    localparam int DIG_MIN10  = 3;
    localparam int DIG_HOUR1  = 4;
    localparam int DIG_HOUR10 = 5;

    // The mode cycle is a plain 2-bit increment; SET_HOUR wraps to CLOCK.
    function automatic logic [1:0] next_mode(input logic [1:0] mode);
        return mode + 2'd1;
    endfunction

    // Digits belonging to the field being edited in a given mode.
    function automatic logic [5:0] field_mask(input logic [1:0] mode);
        logic [5:0] m;
        m = '0;
        case (mode)
            MODE_SET_SEC: begin
                m[DIG_SEC1]  = 1'b1;
                m[DIG_SEC10] = 1'b1;
            end
            MODE_SET_MIN: begin
                m[DIG_MIN1]  = 1'b1;
                m[DIG_MIN10] = 1'b1;
            end
            MODE_SET_HOUR: begin
                m[DIG_HOUR1]  = 1'b1;
                m[DIG_HOUR10] = 1'b1;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

    // Separator dots sit after the hour-ones and minute-ones digits.
    function automatic logic [5:0] sep_dp(input logic t);
        logic [5:0] m;
        m = '0;
        m[DIG_HOUR1] = t;
        m[DIG_MIN1]  = t;
        return m;
    endfunction

endpackage

// File: rtl/wrap_cnt.sv
// wrap_cnt: 6-bit modulo counter used for the seconds, minutes and hours
// fields.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset, clears value to 0
//   i_inc    in   advance by one this cycle (MAX wraps to 0)
//   o_value  out  current count 0..MAX
//   o_carry  out  combinational: i_inc && value == MAX (feeds next field)
module wrap_cnt #(
    parameter logic [5:0] MAX = 6'd59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_inc,
    output logic [5:0] o_value,
    output logic       o_carry
);

    logic [5:0] r_value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
        end else if (i_inc) begin
            r_value <= (r_value == MAX) ? 6'd0 : r_value + 6'd1;
        end
    end

    assign o_value = r_value;
    assign o_carry = i_inc && (r_value == MAX);

endmodule

// File: rtl/hms_set_ctrl.sv
// hms_set_ctrl: timekeeping and time-set controller for a six-digit clock.
// Owns the sec/min/hour registers, the mode FSM, the blink timer for the
// field being edited and the blinking separator dots.
// Optional build macro: HMS_AUTO_EXIT_EN (idle timeout back to CLOCK).
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   i_tick      in   1 Hz one-cycle pulse
//   i_btn_mode  in   one-cycle pulse, advances the mode FSM
//   i_btn_inc   in   one-cycle pulse, increments the selected field
//   o_sec/o_min/o_hour  out  current time fields
//   o_mode      out  FSM state: 0 CLOCK, 1 SET_SEC, 2 SET_MIN, 3 SET_HOUR
//   o_blank     out  per-digit blank mask (bit0 sec ones .. bit5 hour tens)
//   o_six_dp    out  per-digit decimal-point enables, same bit order
// All outputs are registered: a pulse in cycle N shows up in cycle N+1.
module hms_set_ctrl
    import hms_pkg::*;
#(
    parameter int HOUR_MAX        = 24,
    parameter int BLINK_HALF      = 12500000,
    parameter int AUTO_EXIT_TICKS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tick,
    input  logic       i_btn_mode,
    input  logic       i_btn_inc,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [5:0] o_hour,
    output logic [1:0] o_mode,
    output logic [5:0] o_blank,
    output logic [5:0] o_six_dp
);

    localparam logic [5:0]         HOUR_TOP  = 6'(HOUR_MAX - 1);
    localparam int                 BLINK_W   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BLINK_W-1:0] BLINK_TOP = BLINK_W'(BLINK_HALF - 1);

    logic [1:0]         r_mode;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_phase;
    logic               r_dp_tog;
    logic [5:0]         r_blank;
    logic [5:0]         r_six_dp;

    logic               w_is_clock;
    logic               w_inc_sel;
    logic               w_sec_inc;
    logic               w_min_inc;
    logic               w_hour_inc;
    logic               w_sec_carry;
    logic               w_min_carry;
    logic               w_unused_hour_carry;
    logic               w_auto_exit;
    logic [1:0]         w_mode_nxt;
    logic [BLINK_W-1:0] w_blink_cnt_nxt;
    logic               w_phase_nxt;
    logic               w_dp_tog_nxt;

    assign w_is_clock = (r_mode == MODE_CLOCK);
    // A mode press in the same cycle swallows the increment.
    assign w_inc_sel  = i_btn_inc && !i_btn_mode;

    // CLOCK: tick ripples through the carry chain. SET_*: only the edited
    // field sees the button, with no carry into its neighbour.
    assign w_sec_inc  = w_is_clock ? i_tick      : (w_inc_sel && (r_mode == MODE_SET_SEC));
    assign w_min_inc  = w_is_clock ? w_sec_carry : (w_inc_sel && (r_mode == MODE_SET_MIN));
    assign w_hour_inc = w_is_clock ? w_min_carry : (w_inc_sel && (r_mode == MODE_SET_HOUR));

    wrap_cnt #(.MAX(SEC_MAX)) u_sec (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_sec_inc),
        .o_value (o_sec),
        .o_carry (w_sec_carry)
    );

    wrap_cnt #(.MAX(MIN_MAX)) u_min (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_min_inc),
        .o_value (o_min),
        .o_carry (w_min_carry)
    );

    wrap_cnt #(.MAX(HOUR_TOP)) u_hour (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_hour_inc),
        .o_value (o_hour),
        .o_carry (w_unused_hour_carry)
    );

`ifdef HMS_AUTO_EXIT_EN
    localparam int IDLE_W = (AUTO_EXIT_TICKS > 1) ? $clog2(AUTO_EXIT_TICKS + 1) : 1;

    logic [IDLE_W-1:0] r_idle;

    // Exit on the tick that brings the idle count to AUTO_EXIT_TICKS; a
    // tick that coincides with a button press is not counted.
    assign w_auto_exit = !w_is_clock && i_tick && !i_btn_inc && !i_btn_mode &&
                         (r_idle == IDLE_W'(AUTO_EXIT_TICKS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle <= '0;
        end else if (w_is_clock || i_btn_mode || i_btn_inc || w_auto_exit) begin
            r_idle <= '0;
        end else if (i_tick) begin
            r_idle <= r_idle + 1'b1;
        end
    end
`else
    // The timeout length has no effect without the idle timer.
    localparam int unused_auto_exit_ticks = AUTO_EXIT_TICKS;

    assign w_auto_exit = 1'b0;
`endif

    always_comb begin
        w_mode_nxt      = r_mode;
        w_blink_cnt_nxt = r_blink_cnt + 1'b1;
        w_phase_nxt     = r_phase;
        w_dp_tog_nxt    = r_dp_tog ^ (w_is_clock && i_tick);

        if (i_btn_mode) begin
            w_mode_nxt = next_mode(r_mode);
        end else if (w_auto_exit) begin
            w_mode_nxt = MODE_CLOCK;
        end

        // Restart the blink on every mode change so the newly selected
        // field is shown (not blanked) right away.
        if (i_btn_mode || w_auto_exit) begin
            w_blink_cnt_nxt = '0;
            w_phase_nxt     = 1'b0;
        end else if (r_blink_cnt == BLINK_TOP) begin
            w_blink_cnt_nxt = '0;
            w_phase_nxt     = !r_phase;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode      <= MODE_CLOCK;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_dp_tog    <= 1'b0;
            r_blank     <= '0;
            r_six_dp    <= '0;
        end else begin
            r_mode      <= w_mode_nxt;
            r_blink_cnt <= w_blink_cnt_nxt;
            r_phase     <= w_phase_nxt;
            r_dp_tog    <= w_dp_tog_nxt;
            // Masks are built from next-state values so they line up with
            // the mode register in the same cycle.
            r_blank     <= field_mask(w_mode_nxt) & {6{w_phase_nxt}};
            r_six_dp    <= (w_mode_nxt == MODE_CLOCK) ? sep_dp(w_dp_tog_nxt) : 6'd0;
        end
    end

    assign o_mode   = r_mode;
    assign o_blank  = r_blank;
    assign o_six_dp = r_six_dp;

endmodule
